alu_n_acc: RTL and testbench
============================

# alu_n_acc

4-bit ALU plus 8-bit accumulator (high nibble ACC_H, low nibble ACC_L) for the 4-bit microprocessor datapath. ACC_H and ACC_L are independently controlled 4-bit universal shift registers (hold / shift right / shift left / load). ALU operations use ACC_H and the B register, which lets the controller sequence add, subtract, AND, shift-add multiply and restoring divide. The block drives an 8-bit accumulator output with an enable, plus sign and zero flags.

## Interface

- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset; asynchronous, active-low. Clears ACC_H, ACC_L, the quotient bit Q and the carry bit C.
- ah_reset  in  1  synchronous, active-high clear of ACC_H only; overrides hs.
- ah_inen  in  1  when hs=11, selects bus_in instead of the ALU result as the ACC_H load source.
- bus_in  in  4  data bus input.
- breg_in  in  4  B register value, the ALU second operand.
- hs  in  2  ACC_H mode: 00 hold, 01 shift right, 10 shift left, 11 load.
- ls  in  2  ACC_L mode: 00 hold, 01 shift right, 10 shift left, 11 load.
- s_add, s_sub, s_and, s_mul, s_div  in  1 each  ALU operation selects, intended one-hot.
- acc_oen  in  1  output enable, active-high.
- acc_out  out  8  {ACC_H, ACC_L} when acc_oen=1, else 8'h00.
- sign_flag  out  1  combinational, equals ACC_H[3].
- zero_flag  out  1  combinational, 1 when {ACC_H, ACC_L} == 0.

## Operation

- **ALU.** Combinational on ACC_H and breg_in, 5-bit internal result R. Priority when more than one select is high: add > sub > and > mul > div.
  - add: R = H + B.
  - sub: R = H − B, mod 16; R[4] = borrow.
  - and: R = H & B.
  - mul: R = ACC_L[0] ? H + B : H.
  - div: if H ≥ B then R = H − B and qnext = 1; otherwise R = H and qnext = 0.
  - No select: R = H.
- **ACC_H next state**, evaluated in priority order:
  - ah_reset → 0.
  - hs=11 → ah_inen ? bus_in : R[3:0].
  - hs=10 → {H[2:0], ACC_L[3]}.
  - hs=01 → {C, H[3:1]}.
  - hs=00 → hold.
- **ACC_L next state:**
  - ls=11 → ACC_H (current value).
  - ls=10 → {L[2:0], Q}.
  - ls=01 → {ACC_H[0], L[3:1]}.
  - ls=00 → hold.
- **C** loads R[4] on any ACC_H ALU load (hs=11, ah_inen=0, ah_reset=0); otherwise it holds.
- **Q** loads qnext on ACC_H ALU load with s_div selected; otherwise it holds. ah_reset does not affect C or Q.
- **Divide sequence** (dividend in ACC_L, ACC_H=0, B = divisor):
  - Repeat 4×: shift left both (hs=10, ls=10), then conditional subtract (hs=11, ls=00, s_div=1).
  - Final step: shift ACC_L left alone (hs=00, ls=10).
  - Result: quotient in ACC_L, remainder in ACC_H.
- **Multiply sequence** (multiplier in ACC_L, ACC_H=0, B = multiplicand):
  - Repeat 4×: load with s_mul (hs=11, ls=00), then shift right both (hs=01, ls=01).
  - Result: 8-bit product in {ACC_H, ACC_L}.
- Divide by zero is not trapped. H ≥ 0 is always true, so every step sets Q=1 and the quotient is 4'hF.

## Timing

- Reset values: ACC_H=0, ACC_L=0, Q=0, C=0. Therefore acc_out=0, sign_flag=0, zero_flag=1.
- clr asserted mid-sequence clears all state immediately and asynchronously.
- Single-cycle latency: register updates are visible on acc_out and the flags right after the clock edge.
- Both nibbles update on the same edge from pre-edge values. Cross-nibble shifts (H←L[3], L←H[0]) and ls=11 use the old values.
- acc_oen gates the output combinationally and has no effect on internal state.

## Test plan

- **Reset / output enable.** Hold clr=0, then release. Expect acc_out=00, zero_flag=1. With ACC=0x13, acc_oen=0 gives acc_out=00.
- **Load path.** bus_in=7, ah_inen=1, hs=11 → ACC=0x70, sign_flag=0. Then ls=11 → 0x77. Then ah_reset=1 for one cycle → 0x07.
- **Divide 7/2.** Start from 0x07, breg_in=2, run the divide sequence above. Expect ACC=0x13 (quotient 3, remainder 1).
- **Add / sub / and**, with ACC_H=5, B=3:
  - add → H=8, sign_flag=1.
  - sub → H=2.
  - 3 − 5 → H=0xE, C=1.
  - 5 & 3 → H=1.
- **Multiply 6×5.** ACC=0x06, B=5, run the multiply sequence. Expect ACC=0x1E.
- **Priority / edge cases.** ah_reset together with hs=11, ah_inen=1 → H=0. Divide 9/0 → quotient F.

Source files
------------

// File: rtl/alu_n_acc.sv
// 4-bit ALU with an 8-bit accumulator split into two universal shift-register nibbles.
// The controller sequences add/sub/and plus shift-add multiply and restoring divide.
module alu_n_acc (
    input  logic       clk,
    input  logic       clr,
    input  logic       ah_reset,
    input  logic       ah_inen,
    input  logic [3:0] bus_in,
    input  logic [3:0] breg_in,
    input  logic [1:0] hs,
    input  logic [1:0] ls,
    input  logic       s_add,
    input  logic       s_sub,
    input  logic       s_and,
    input  logic       s_mul,
    input  logic       s_div,
    input  logic       acc_oen,
    output logic [7:0] acc_out,
    output logic       sign_flag,
    output logic       zero_flag
);

    logic [3:0] acc_h, acc_l;
    logic       q, c;
    logic [4:0] r;
    logic [4:0] sum;
    logic       qnext;
    logic       alu_load;

    assign sum      = {1'b0, acc_h} + {1'b0, breg_in};
    assign alu_load = !ah_reset && (hs == 2'b11) && !ah_inen;

    always_comb begin
        r     = {1'b0, acc_h};
        qnext = 1'b0;
        if (s_add)
            r = sum;
        else if (s_sub)
            r = {1'b0, acc_h} - {1'b0, breg_in};   // bit 4 becomes the borrow
        else if (s_and)
            r = {1'b0, acc_h & breg_in};
        else if (s_mul)
            r = acc_l[0] ? sum : {1'b0, acc_h};
        else if (s_div) begin
            if (acc_h >= breg_in) begin
                r     = {1'b0, acc_h - breg_in};
                qnext = 1'b1;
            end
        end
    end

    // Both nibbles update from pre-edge values, so cross-nibble shifts see old data.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_h <= 4'h0;
            acc_l <= 4'h0;
            q     <= 1'b0;
            c     <= 1'b0;
        end else begin
            if (ah_reset)
                acc_h <= 4'h0;
            else begin
                case (hs)
                    2'b11:   acc_h <= ah_inen ? bus_in : r[3:0];
                    2'b10:   acc_h <= {acc_h[2:0], acc_l[3]};
                    2'b01:   acc_h <= {c, acc_h[3:1]};
                    default: acc_h <= acc_h;
                endcase
            end
            case (ls)
                2'b11:   acc_l <= acc_h;
                2'b10:   acc_l <= {acc_l[2:0], q};
                2'b01:   acc_l <= {acc_h[0], acc_l[3:1]};
                default: acc_l <= acc_l;
            endcase
            if (alu_load)
                c <= r[4];
            if (alu_load && s_div)
                q <= qnext;
        end
    end

    assign acc_out   = acc_oen ? {acc_h, acc_l} : 8'h00;
    assign sign_flag = acc_h[3];
    assign zero_flag = ({acc_h, acc_l} == 8'h00);

endmodule

// File: tb/tb_alu_n_acc.sv
// Directed bench for alu_n_acc: load paths, ALU ops, multiply/divide sequences, reset and output enable.
module tb_alu_n_acc;

    logic       clk = 1'b0;
    logic       clr;
    logic       ah_reset, ah_inen;
    logic [3:0] bus_in, breg_in;
    logic [1:0] hs, ls;
    logic       s_add, s_sub, s_and, s_mul, s_div;
    logic       acc_oen;
    logic [7:0] acc_out;
    logic       sign_flag, zero_flag;

    int n_tests = 0;
    int n_fail  = 0;

    alu_n_acc dut (
        .clk(clk), .clr(clr), .ah_reset(ah_reset), .ah_inen(ah_inen),
        .bus_in(bus_in), .breg_in(breg_in), .hs(hs), .ls(ls),
        .s_add(s_add), .s_sub(s_sub), .s_and(s_and), .s_mul(s_mul), .s_div(s_div),
        .acc_oen(acc_oen), .acc_out(acc_out), .sign_flag(sign_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    // One clocked step; sel = {add, sub, and, mul, div}. Controls return to idle afterwards.
    task automatic op(input logic rst, input logic [1:0] h, input logic [1:0] l,
                      input logic inen, input logic [3:0] bus, input logic [4:0] sel);
        ah_reset = rst; hs = h; ls = l; ah_inen = inen; bus_in = bus;
        {s_add, s_sub, s_and, s_mul, s_div} = sel;
        @(posedge clk); #1;
        ah_reset = 1'b0; hs = 2'b00; ls = 2'b00; ah_inen = 1'b0; bus_in = 4'h0;
        {s_add, s_sub, s_and, s_mul, s_div} = 5'b0;
    endtask

    // Set ACC = {0, v} through the bus, copy to ACC_L, then clear ACC_H.
    task automatic load_low(input logic [3:0] v);
        op(1'b0, 2'b11, 2'b00, 1'b1, v, 5'b0);
        op(1'b0, 2'b00, 2'b11, 1'b0, 4'h0, 5'b0);
        op(1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 5'b0);
    endtask

    task automatic divide_seq();
        repeat (4) begin
            op(1'b0, 2'b10, 2'b10, 1'b0, 4'h0, 5'b0);
            op(1'b0, 2'b11, 2'b00, 1'b0, 4'h0, 5'b00001);
        end
        op(1'b0, 2'b00, 2'b10, 1'b0, 4'h0, 5'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (acc_out !== 8'h00 || zero_flag !== 1'b1 || sign_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: acc=%h z=%b s=%b, want acc=00 z=1 s=0", acc_out, zero_flag, sign_flag);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (acc_out !== 8'h00 || zero_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: acc=%h z=%b, want acc=00 z=1", acc_out, zero_flag);
        end
    endtask

    task automatic test_load();
        op(1'b0, 2'b11, 2'b00, 1'b1, 4'h7, 5'b0);
        n_tests++;
        if (acc_out !== 8'h70 || sign_flag !== 1'b0 || zero_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL load_bus: acc=%h s=%b z=%b, want acc=70 s=0 z=0", acc_out, sign_flag, zero_flag);
        end
        op(1'b0, 2'b00, 2'b11, 1'b0, 4'h0, 5'b0);
        n_tests++;
        if (acc_out !== 8'h77) begin
            n_fail++;
            $display("FAIL load_low: acc=%h, want 77", acc_out);
        end
        op(1'b1, 2'b00, 2'b00, 1'b0, 4'h0, 5'b0);
        n_tests++;
        if (acc_out !== 8'h07) begin
            n_fail++;
            $display("FAIL ah_reset: acc=%h, want 07", acc_out);
        end
    endtask

    task automatic test_divide();
        breg_in = 4'h2;
        divide_seq();
        n_tests++;
        if (acc_out !== 8'h13) begin
            n_fail++;
            $display("FAIL div_7_2: acc=%h, want 13", acc_out);
        end
    endtask

    task automatic test_oen();
        acc_oen = 1'b0;
        #1;
        n_tests++;
        if (acc_out !== 8'h00 || zero_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL oen_off: acc=%h z=%b, want acc=00 z=0", acc_out, zero_flag);
        end
        acc_oen = 1'b1;
        #1;
        n_tests++;
        if (acc_out !== 8'h13) begin
            n_fail++;
            $display("FAIL oen_on: acc=%h, want 13", acc_out);
        end
    endtask

    task automatic test_alu();
        // ACC_L stays 3 from the divide; only ACC_H changes here.
        breg_in = 4'h3;
        op(1'b0, 2'b11, 2'b00, 1'b1, 4'h5, 5'b0);
        op(1'b0, 2'b11, 2'b00, 1'b0, 4'h0, 5'b10000);
        n_tests++;
        if (acc_out !== 8'h83 || sign_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL add_5_3: acc=%h s=%b, want acc=83 s=1", acc_out, sign_flag);
        end
        op(1'b0, 2'b11, 2'b00, 1'b1, 4'h5, 5'b0);
        op(1'b0, 2'b11, 2'b00, 1'b0, 4'h0, 5'b01000);
        n_tests++;
        if (acc_out !== 8'h23) begin
            n_fail++;
            $display("FAIL sub_5_3: acc=%h, want 23", acc_out);
        end
        breg_in = 4'h5;
        op(1'b0, 2'b11, 2'b00, 1'b1, 4'h3, 5'b0);
        op(1'b0, 2'b11, 2'b00, 1'b0, 4'h0, 5'b01000);
        n_tests++;
        if (acc_out !== 8'hE3) begin
            n_fail++;
            $display("FAIL sub_3_5: acc=%h, want E3", acc_out);
        end
        // Borrow latched in C shows up as the MSB on a right shift of ACC_H.
        op(1'b0, 2'b01, 2'b00, 1'b0, 4'h0, 5'b0);
        n_tests++;
        if (acc_out !== 8'hF3) begin
            n_fail++;
            $display("FAIL borrow_c: acc=%h, want F3", acc_out);
        end
        breg_in = 4'h3;
        op(1'b0, 2'b11, 2'b00, 1'b1, 4'h5, 5'b0);
        op(1'b0, 2'b11, 2'b00, 1'b0, 4'h0, 5'b00100);
        n_tests++;
        if (acc_out !== 8'h13) begin
            n_fail++;
            $display("FAIL and_5_3: acc=%h, want 13", acc_out);
        end
    endtask

    task automatic test_multiply();
        load_low(4'h6);
        n_tests++;
        if (acc_out !== 8'h06) begin
            n_fail++;
            $display("FAIL mul_setup: acc=%h, want 06", acc_out);
        end
        breg_in = 4'h5;
        repeat (4) begin
            op(1'b0, 2'b11, 2'b00, 1'b0, 4'h0, 5'b00010);
            op(1'b0, 2'b01, 2'b01, 1'b0, 4'h0, 5'b0);
        end
        n_tests++;
        if (acc_out !== 8'h1E) begin
            n_fail++;
            $display("FAIL mul_6_5: acc=%h, want 1E", acc_out);
        end
    endtask

    task automatic test_priority();
        op(1'b1, 2'b11, 2'b00, 1'b1, 4'hA, 5'b0);
        n_tests++;
        if (acc_out !== 8'h0E) begin
            n_fail++;
            $display("FAIL ah_reset_prio: acc=%h, want 0E", acc_out);
        end
    endtask

    task automatic test_div_zero();
        load_low(4'h9);
        breg_in = 4'h0;
        divide_seq();
        n_tests++;
        if (acc_out !== 8'h9F) begin
            n_fail++;
            $display("FAIL div_9_0: acc=%h, want 9F", acc_out);
        end
    endtask

    task automatic test_async_clr();
        breg_in = 4'h2;
        load_low(4'hB);
        op(1'b0, 2'b10, 2'b10, 1'b0, 4'h0, 5'b0);
        #2 clr = 1'b0;
        #1;
        n_tests++;
        if (acc_out !== 8'h00 || zero_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL async_clr: acc=%h z=%b, want acc=00 z=1", acc_out, zero_flag);
        end
        @(posedge clk); #1;
        clr = 1'b1;
        op(1'b0, 2'b10, 2'b10, 1'b0, 4'h0, 5'b0);
        n_tests++;
        if (acc_out !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_q_cleared: acc=%h, want 00", acc_out);
        end
    endtask

    initial begin
        clr = 1'b0; ah_reset = 1'b0; ah_inen = 1'b0; bus_in = 4'h0; breg_in = 4'h0;
        hs = 2'b00; ls = 2'b00; {s_add, s_sub, s_and, s_mul, s_div} = 5'b0; acc_oen = 1'b1;
        test_reset();
        test_load();
        test_divide();
        test_oen();
        test_alu();
        test_multiply();
        test_priority();
        test_div_zero();
        test_async_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
